alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have port clock  in  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports req_valid in 1 and req_ready out 1, the request handshake.
REQ-004 SHALL have ports opcode in 6, funct in 6, operand_a in 32 and operand_b in 32, the request payload.
REQ-005 SHALL have ports alu_control out 4, alu_a out 32 and alu_b out 32, driving the combinational 32-bit ALU.
REQ-006 SHALL have ports alu_result in 32, alu_zero in 1, alu_overflow in 1 and alu_invalid in 1, returned by the ALU.
REQ-007 SHALL have ports rsp_valid out 1 and rsp_ready in 1, the response handshake.
REQ-008 SHALL have ports rsp_result out 32, rsp_zero out 1, rsp_overflow out 1, rsp_error out 1 and err_sticky out 1, the response payload and status.

Function
REQ-009 SHALL implement FSM states IDLE, EXEC, DONE; req_ready=1 only in IDLE; rsp_valid=1 only in DONE.
REQ-010 SHALL, in IDLE with req_valid=1, latch operand_a, operand_b and the decoded control, then go to EXEC; with a decode miss, go straight to DONE with rsp_error=1, rsp_result=0, rsp_zero=0, rsp_overflow=0.
REQ-011 SHALL decode R-type (opcode 0x00) by funct: 0x20 add->0x2, 0x21 addu->0x3, 0x22 sub->0x6, 0x23 subu->0x6, 0x24 and->0x0, 0x25 or->0x1, 0x27 nor->0xC, 0x2A slt->0x7; any other funct is a decode miss.
REQ-012 SHALL decode I-type by opcode: 0x08 addi->0x2, 0x09 addiu->0x3, 0x0A slti->0x7, 0x0C andi->0x0, 0x0D ori->0x1, 0x04 beq->0x6, 0x05 bne->0x6, 0x23 lw->0x2, 0x2B sw->0x2; any other opcode is a decode miss.
REQ-013 SHALL drive alu_a, alu_b and alu_control from the latched registers only, holding them stable from EXEC through DONE.
REQ-014 SHALL, at the end of the single EXEC cycle, capture alu_result to rsp_result and alu_zero to rsp_zero, set rsp_error=alu_invalid, and go to DONE.
REQ-015 SHALL set rsp_overflow=alu_overflow only for add, sub and addi; for all other operations rsp_overflow SHALL be 0, with subu included in the forced-0 set.
REQ-016 SHALL keep the response payload stable in DONE until rsp_valid and rsp_ready are both 1, then return to IDLE.
REQ-017 SHALL take 2 cycles from request acceptance to rsp_valid for a decoded op, and 1 cycle for a decode miss.
REQ-018 SHALL ignore req_valid outside IDLE; a request presented while busy SHALL be held by the requester and not lost.
REQ-019 SHALL not accept a new request in the same cycle a response completes; the earliest next acceptance is the cycle after.

Reset
REQ-020 SHALL, with reset=1 at a clock edge, enter IDLE and clear every output and latched register: alu_control=0x0, alu_a=0, alu_b=0, rsp_*=0 and err_sticky=0.
REQ-021 SHALL take priority over all handshakes; reset in EXEC or DONE SHALL discard the in-flight operation without asserting rsp_valid.
REQ-022 SHALL assert req_ready=1 in the first cycle after reset deasserts.

Configuration
REQ-023 SHALL, with ALU_ISSUE_STICKY_ERR_EN defined, set err_sticky=1 on any cycle that completes a response with rsp_error=1 or rsp_overflow=1, and hold it at 1 until reset.
REQ-024 SHALL, without ALU_ISSUE_STICKY_ERR_EN defined, tie err_sticky to 0; the port SHALL still exist.

Verification
REQ-025 Bench SHALL cover add: opcode 0x00, funct 0x20, a=5, b=7 -> rsp_valid 2 cycles after acceptance, rsp_result=12, rsp_zero=0, rsp_overflow=0, alu_control=0x2.
REQ-026 Bench SHALL cover signed overflow: add with a=0x7FFFFFFF, b=1 -> rsp_result=0x80000000, rsp_overflow=1; addu with the same operands -> rsp_overflow=0.
REQ-027 Bench SHALL cover a decode miss: opcode 0x3F -> rsp_valid after 1 cycle, rsp_error=1, rsp_result=0; err_sticky=1 only when the macro is defined.
REQ-028 Bench SHALL cover backpressure: beq with a=9, b=9 and rsp_ready=0 for 5 cycles -> rsp_zero=1 and the payload stable throughout, req_ready=0; req_ready=1 the cycle after rsp_ready=1.
REQ-029 Bench SHALL cover reset in EXEC: reset asserted the cycle after acceptance -> no rsp_valid, all outputs 0, req_ready=1 the cycle after reset is released.

Source files
------------

// File: rtl/alu_issue.sv
// alu_issue: single-outstanding issue stage in front of a combinational
// 32-bit ALU. Decodes a MIPS-style opcode/funct pair into an ALU control
// code, presents latched operands to the ALU for one EXEC cycle, captures the
// ALU outputs and holds them as a response until the consumer takes it.
// Optional feature: define ALU_ISSUE_STICKY_ERR_EN to make err_sticky record
// any completed response that carried an error or a signed overflow.
module alu_issue (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic [3:0]  alu_control,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  input  logic        alu_invalid,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_overflow,
  output logic        rsp_error,
  output logic        err_sticky
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  ctrl_reg;
  logic [31:0] a_reg, b_reg;
  logic        ovf_en_reg;
  logic [31:0] result_reg;
  logic        zero_reg, ovf_reg, err_reg;

  logic        dec_hit;
  logic [3:0]  dec_ctrl;
  logic        dec_ovf_en;

  // Decode opcode/funct into ALU control; only add, sub and addi report overflow
  always_comb begin
    dec_hit    = 1'b1;
    dec_ctrl   = 4'h0;
    dec_ovf_en = 1'b0;
    if (opcode == 6'h00) begin
      case (funct)
        6'h20: begin dec_ctrl = 4'h2; dec_ovf_en = 1'b1; end
        6'h21: dec_ctrl = 4'h3;
        6'h22: begin dec_ctrl = 4'h6; dec_ovf_en = 1'b1; end
        6'h23: dec_ctrl = 4'h6;
        6'h24: dec_ctrl = 4'h0;
        6'h25: dec_ctrl = 4'h1;
        6'h27: dec_ctrl = 4'hC;
        6'h2A: dec_ctrl = 4'h7;
        default: dec_hit = 1'b0;
      endcase
    end else begin
      case (opcode)
        6'h08: begin dec_ctrl = 4'h2; dec_ovf_en = 1'b1; end
        6'h09: dec_ctrl = 4'h3;
        6'h0A: dec_ctrl = 4'h7;
        6'h0C: dec_ctrl = 4'h0;
        6'h0D: dec_ctrl = 4'h1;
        6'h04: dec_ctrl = 4'h6;
        6'h05: dec_ctrl = 4'h6;
        6'h23: dec_ctrl = 4'h2;
        6'h2B: dec_ctrl = 4'h2;
        default: dec_hit = 1'b0;
      endcase
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next state: a decode miss skips EXEC since there is nothing to compute
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_valid) state_next = dec_hit ? EXEC : DONE;
      EXEC:    state_next = DONE;
      DONE:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs are pure functions of state
  always_comb begin
    req_ready = (state_reg == IDLE);
    rsp_valid = (state_reg == DONE);
  end

  // Operand/control latch on acceptance and response capture at end of EXEC
  always_ff @(posedge clock) begin
    if (reset) begin
      ctrl_reg   <= 4'h0;
      a_reg      <= 32'h0;
      b_reg      <= 32'h0;
      ovf_en_reg <= 1'b0;
      result_reg <= 32'h0;
      zero_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            if (dec_hit) begin
              ctrl_reg   <= dec_ctrl;
              a_reg      <= operand_a;
              b_reg      <= operand_b;
              ovf_en_reg <= dec_ovf_en;
            end else begin
              result_reg <= 32'h0;
              zero_reg   <= 1'b0;
              ovf_reg    <= 1'b0;
              err_reg    <= 1'b1;
            end
          end
        end
        EXEC: begin
          result_reg <= alu_result;
          zero_reg   <= alu_zero;
          ovf_reg    <= ovf_en_reg & alu_overflow;
          err_reg    <= alu_invalid;
        end
        default: ;
      endcase
    end
  end

  assign alu_control  = ctrl_reg;
  assign alu_a        = a_reg;
  assign alu_b        = b_reg;
  assign rsp_result   = result_reg;
  assign rsp_zero     = zero_reg;
  assign rsp_overflow = ovf_reg;
  assign rsp_error    = err_reg;

`ifdef ALU_ISSUE_STICKY_ERR_EN
  logic sticky_reg;

  // Remember any delivered response that carried an error or overflow
  always_ff @(posedge clock) begin
    if (reset)
      sticky_reg <= 1'b0;
    else if (rsp_valid && rsp_ready && (err_reg || ovf_reg))
      sticky_reg <= 1'b1;
  end

  assign err_sticky = sticky_reg;
`else
  assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed cases with literal expectations
// followed by randomized traffic checked every cycle against a transaction
// level model. The bench also plays the role of the combinational ALU.
module tb_alu_issue;

  logic        clock = 1'b0;
  logic        reset, req_valid, req_ready, rsp_valid, rsp_ready;
  logic [5:0]  opcode, funct;
  logic [31:0] operand_a, operand_b;
  logic [3:0]  alu_control;
  logic [31:0] alu_a, alu_b, alu_result, rsp_result;
  logic        alu_zero, alu_overflow, alu_invalid;
  logic        rsp_zero, rsp_overflow, rsp_error, err_sticky;

`ifdef ALU_ISSUE_STICKY_ERR_EN
  localparam bit STICKY_ON = 1'b1;
`else
  localparam bit STICKY_ON = 1'b0;
`endif

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  bit rnd_en = 1'b0;
  logic inj_req = 1'b0;
  logic inj_cur = 1'b0;

  alu_issue dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .opcode(opcode), .funct(funct), .operand_a(operand_a), .operand_b(operand_b),
    .alu_control(alu_control), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .alu_invalid(alu_invalid), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow),
    .rsp_error(rsp_error), .err_sticky(err_sticky)
  );

  always #5 clock = ~clock;

  // ---------------- reference ALU arithmetic ----------------
  function automatic logic [31:0] alu_res(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'h0:       return a & b;
      4'h1:       return a | b;
      4'h2, 4'h3: return a + b;
      4'h6:       return a - b;
      4'h7:       return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'hC:       return ~(a | b);
      default:    return 32'h0;
    endcase
  endfunction

  // Signed overflow as a real ALU sees it; the issue stage decides whether to report it
  function automatic logic alu_ovf(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] s;
    s = alu_res(c, a, b);
    if (c == 4'h2 || c == 4'h3) return (a[31] == b[31]) && (s[31] != a[31]);
    if (c == 4'h6)              return (a[31] != b[31]) && (s[31] != a[31]);
    return 1'b0;
  endfunction

  function automatic logic ctrl_ok(input logic [3:0] c);
    return c inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h6, 4'h7, 4'hC};
  endfunction

  assign alu_result   = alu_res(alu_control, alu_a, alu_b);
  assign alu_zero     = (alu_result == 32'h0);
  assign alu_overflow = alu_ovf(alu_control, alu_a, alu_b);
  assign alu_invalid  = inj_cur | ~ctrl_ok(alu_control);

  // Decode table: {hit, reports_overflow, ctrl}
  function automatic logic [5:0] decode(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) begin
      case (fn)
        6'h20: return 6'b11_0010;
        6'h21: return 6'b10_0011;
        6'h22: return 6'b11_0110;
        6'h23: return 6'b10_0110;
        6'h24: return 6'b10_0000;
        6'h25: return 6'b10_0001;
        6'h27: return 6'b10_1100;
        6'h2A: return 6'b10_0111;
        default: return 6'b00_0000;
      endcase
    end
    case (op)
      6'h08: return 6'b11_0010;
      6'h09: return 6'b10_0011;
      6'h0A: return 6'b10_0111;
      6'h0C: return 6'b10_0000;
      6'h0D: return 6'b10_0001;
      6'h04, 6'h05: return 6'b10_0110;
      6'h23, 6'h2B: return 6'b10_0010;
      default: return 6'b00_0000;
    endcase
  endfunction

  // ---------------- transaction-level model ----------------
  bit          m_busy = 1'b0, m_wait = 1'b0, m_sticky = 1'b0;
  bit          m_alu_known = 1'b0, m_pay_known = 1'b0;
  logic [3:0]  m_ctrl = 4'h0;
  logic [31:0] m_a = 32'h0, m_b = 32'h0, m_res = 32'h0;
  logic        m_zero = 1'b0, m_ovf = 1'b0, m_err = 1'b0;
  logic [5:0]  m_op = 6'h0, m_fn = 6'h0;

  always @(posedge clock) begin
    logic [5:0] d;
    if (reset) begin
      m_busy = 0; m_wait = 0; m_sticky = 0;
      m_alu_known = 1; m_pay_known = 1;
      m_ctrl = 4'h0; m_a = 32'h0; m_b = 32'h0;
      m_res = 32'h0; m_zero = 0; m_ovf = 0; m_err = 0;
      inj_cur <= 1'b0;
    end else if (!m_busy) begin
      if (req_valid) begin
        d = decode(opcode, funct);
        m_busy = 1; m_op = opcode; m_fn = funct;
        if (d[5]) begin
          m_wait = 1; m_alu_known = 1; m_pay_known = 0;
          m_ctrl = d[3:0]; m_a = operand_a; m_b = operand_b;
          m_res  = alu_res(m_ctrl, m_a, m_b);
          m_zero = (m_res == 32'h0);
          m_ovf  = d[4] & alu_ovf(m_ctrl, m_a, m_b);
          m_err  = inj_req;
          inj_cur <= inj_req;
        end else begin
          m_wait = 0; m_alu_known = 0; m_pay_known = 1;
          m_res = 32'h0; m_zero = 0; m_ovf = 0; m_err = 1;
        end
      end
    end else if (m_wait) begin
      m_wait = 0; m_pay_known = 1;
    end else if (rsp_ready) begin
      m_busy = 0;
      if (STICKY_ON && (m_err || m_ovf)) m_sticky = 1;
      $display("txn op=%02h fn=%02h a=%08h b=%08h -> res=%08h z=%0d ovf=%0d err=%0d",
               m_op, m_fn, m_a, m_b, m_res, m_zero, m_ovf, m_err);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, 32'(act), 32'(exp));
  endtask

  // Per-cycle comparison of every meaningful DUT output against the model
  always @(negedge clock) begin
    if (chk_en) begin
      chk1("m_req_ready", req_ready, !m_busy);
      chk1("m_rsp_valid", rsp_valid, m_busy && !m_wait);
      chk1("m_err_sticky", err_sticky, m_sticky);
      if (m_pay_known) begin
        chk("m_rsp_result", rsp_result, m_res);
        chk1("m_rsp_zero", rsp_zero, m_zero);
        chk1("m_rsp_overflow", rsp_overflow, m_ovf);
        chk1("m_rsp_error", rsp_error, m_err);
      end
      if (m_alu_known) begin
        chk("m_alu_control", 32'(alu_control), 32'(m_ctrl));
        chk("m_alu_a", alu_a, m_a);
        chk("m_alu_b", alu_b, m_b);
      end
    end
  end

  // Random consumer backpressure during the randomized phase
  initial begin
    forever begin
      @(negedge clock);
      if (rnd_en) rsp_ready = ($urandom_range(0, 9) < 7);
    end
  end

  // Present a request at a negedge and return at the negedge after acceptance
  task automatic send(input logic [5:0] op, input logic [5:0] fn,
                      input logic [31:0] a, input logic [31:0] b, input logic inv);
    int n;
    req_valid = 1'b1; opcode = op; funct = fn;
    operand_a = a; operand_b = b; inj_req = inv;
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) chk1("accept_timeout", 1'b0, 1'b1);
    @(negedge clock);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  logic [5:0] r_fn [8] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A};
  logic [5:0] i_op [9] = '{6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h04, 6'h05, 6'h23, 6'h2B};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, n;
    logic [5:0] op, fn;
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    opcode = 6'h0; funct = 6'h0; operand_a = 32'h0; operand_b = 32'h0;
    repeat (3) @(negedge clock);
    chk_en = 1'b1;
    reset = 1'b0;
    @(negedge clock);
    chk1("rst_req_ready", req_ready, 1'b1);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_alu_control", 32'(alu_control), 32'h0);
    chk("rst_rsp_result", rsp_result, 32'h0);
    chk1("rst_err_sticky", err_sticky, 1'b0);

    // add 5 + 7
    rsp_ready = 1'b1;
    send(6'h00, 6'h20, 32'd5, 32'd7, 1'b0);
    req_valid = 1'b0;
    chk1("add_valid_c1", rsp_valid, 1'b0);
    chk("add_alu_control", 32'(alu_control), 32'h2);
    @(negedge clock);
    chk1("add_valid_c2", rsp_valid, 1'b1);
    chk("add_result", rsp_result, 32'd12);
    chk1("add_zero", rsp_zero, 1'b0);
    chk1("add_ovf", rsp_overflow, 1'b0);
    @(negedge clock);
    chk1("add_ready_after", req_ready, 1'b1);

    // signed overflow on add, masked on addu
    send(6'h00, 6'h20, 32'h7FFF_FFFF, 32'd1, 1'b0);
    req_valid = 1'b0;
    @(negedge clock);
    chk("addovf_result", rsp_result, 32'h8000_0000);
    chk1("addovf_ovf", rsp_overflow, 1'b1);
    @(negedge clock);
    chk1("addovf_sticky", err_sticky, STICKY_ON);
    send(6'h00, 6'h21, 32'h7FFF_FFFF, 32'd1, 1'b0);
    req_valid = 1'b0;
    @(negedge clock);
    chk("addu_result", rsp_result, 32'h8000_0000);
    chk1("addu_ovf", rsp_overflow, 1'b0);
    @(negedge clock);

    // beq with consumer stalled for 5 cycles
    rsp_ready = 1'b0;
    send(6'h04, 6'h00, 32'd9, 32'd9, 1'b0);
    req_valid = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      chk1("bp_valid", rsp_valid, 1'b1);
      chk1("bp_zero", rsp_zero, 1'b1);
      chk("bp_result", rsp_result, 32'h0);
      chk1("bp_ovf", rsp_overflow, 1'b0);
      chk1("bp_req_ready", req_ready, 1'b0);
      chk("bp_alu_control", 32'(alu_control), 32'h6);
      @(negedge clock);
    end
    rsp_ready = 1'b1;
    chk1("bp_req_ready_release", req_ready, 1'b0);
    @(negedge clock);
    chk1("bp_req_ready_after", req_ready, 1'b1);

    // decode miss
    send(6'h3F, 6'h00, 32'd3, 32'd4, 1'b0);
    req_valid = 1'b0;
    chk1("miss_valid_c1", rsp_valid, 1'b1);
    chk1("miss_error", rsp_error, 1'b1);
    chk("miss_result", rsp_result, 32'h0);
    chk1("miss_ovf", rsp_overflow, 1'b0);
    @(negedge clock);
    chk1("miss_ready_after", req_ready, 1'b1);
    chk1("miss_sticky", err_sticky, STICKY_ON);

    // reset the cycle after acceptance
    send(6'h00, 6'h20, 32'd5, 32'd7, 1'b0);
    req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    chk1("rexec_valid", rsp_valid, 1'b0);
    chk("rexec_result", rsp_result, 32'h0);
    chk("rexec_alu_control", 32'(alu_control), 32'h0);
    chk("rexec_alu_a", alu_a, 32'h0);
    chk("rexec_alu_b", alu_b, 32'h0);
    chk1("rexec_error", rsp_error, 1'b0);
    chk1("rexec_sticky", err_sticky, 1'b0);
    reset = 1'b0;
    @(negedge clock);
    chk1("rexec_ready_after", req_ready, 1'b1);
    chk1("rexec_valid_after", rsp_valid, 1'b0);

    // randomized traffic; requests are held while the DUT is busy
    rnd_en = 1'b1;
    for (int t = 0; t < 400; t++) begin
      k = $urandom_range(0, 19);
      if (k < 8) begin
        op = 6'h00; fn = r_fn[$urandom_range(0, 7)];
      end else if (k < 17) begin
        op = i_op[$urandom_range(0, 8)]; fn = 6'($urandom);
      end else if (k == 17) begin
        op = 6'h00; fn = 6'($urandom);
      end else begin
        op = 6'($urandom); fn = 6'($urandom);
      end
      send(op, fn, pick_operand(), pick_operand(), ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 59) == 0) begin
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) begin
        req_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clock);
      end
    end

    req_valid = 1'b0;
    rnd_en = 1'b0;
    @(negedge clock);
    rsp_ready = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk1("drain_idle", req_ready, 1'b1);
    @(negedge clock);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
